// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM sequencing the multicycle RV32I datapath
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (illegal instructions enter HALT and raise Illegal)
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   Opcode, Funct3, Funct7b5    instruction fields from the instruction register
//   Zero                        ALU zero flag
//   PcEn, AdrSrc, MemWrite      PC load, address select, memory write
//   IrWrite, RegWrite           instruction register load, register file write
//   Immsrc, AluSrcA, AluSrcB    immediate format, ALU operand selects
//   AluOp, ResultSrc            ALU operation, result mux select
//   Illegal                     high in HALT (only with CTRL_ILLEGAL_TRAP_EN)
module multicycle_controller #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Opcode,
    input  logic [2:0] Funct3,
    input  logic       Funct7b5,
    input  logic       Zero,
    output logic       PcEn,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IrWrite,
    output logic       RegWrite,
    output logic [2:0] Immsrc,
    output logic [1:0] AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [2:0] AluOp,
    output logic [1:0] ResultSrc
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic       Illegal
`endif
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, HALT
    } state_t;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam state_t TRAP = HALT;
    assign Illegal = state == HALT;
`else
    localparam state_t TRAP = FETCH;
`endif
    state_t state, state_d;
    logic [3:0] cnt;
    logic last, taken, bad_br, pc_update, branch, mem_w, ir_w, reg_w;
    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub);
        return f3 == 3'b000 ? (sub ? 3'b001 : 3'b000) :
               f3 == 3'b111 ? 3'b010 :
               f3 == 3'b110 ? 3'b011 :
               f3 == 3'b010 ? 3'b100 :
               f3 == 3'b100 ? 3'b101 : 3'b000;
    endfunction
    assign last   = cnt == 4'd0;
    assign taken  = Funct3[0] ? ~Zero : Zero;
    assign bad_br = Funct3[2:1] != 2'b00;
    assign Immsrc = Opcode == 7'b0100011 ? 3'b001 :
                    Opcode == 7'b1100011 ? 3'b010 :
                    Opcode == 7'b1101111 ? 3'b011 :
                    Opcode == 7'b0110111 ? 3'b100 : 3'b000;
    // Enables are gated by rst so an abort takes effect without waiting for a clock edge.
    assign PcEn     = rst & (pc_update | (branch & taken));
    assign MemWrite = rst & mem_w;
    assign IrWrite  = rst & ir_w;
    assign RegWrite = rst & reg_w;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
            cnt   <= '0;
        end else begin
            state <= state_d;
            // Wait states reload the counter on entry; otherwise it counts down to 0.
            if (state_d != state && (state_d == FETCH || state_d == MEMREAD || state_d == MEMWRITE))
                cnt <= 4'(MEM_WAIT);
            else if (!last)
                cnt <= cnt - 4'd1;
        end
    end
    always_comb begin
        state_d   = state;
        AdrSrc    = 1'b0;
        mem_w     = 1'b0;
        ir_w      = 1'b0;
        reg_w     = 1'b0;
        pc_update = 1'b0;
        branch    = 1'b0;
        AluSrcA   = 2'b00;
        AluSrcB   = 2'b00;
        AluOp     = 3'b000;
        ResultSrc = 2'b00;
        case (state)
            FETCH: begin
                AluSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_w      = last;
                pc_update = last;
                state_d   = last ? DECODE : FETCH;
            end
            DECODE: begin
                AluSrcA = 2'b01;
                AluSrcB = 2'b01;
                case (Opcode)
                    7'b0000011, 7'b0100011: state_d = MEMADR;
                    7'b0110011:             state_d = EXECR;
                    7'b0010011:             state_d = EXECI;
                    7'b1100011:             state_d = BRANCH;
                    7'b1101111:             state_d = JAL;
                    7'b0110111:             state_d = LUI;
                    default:                state_d = TRAP;
                endcase
            end
            MEMADR: begin
                AluSrcA = 2'b10;
                AluSrcB = 2'b01;
                state_d = Opcode[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = last ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                AdrSrc  = 1'b1;
                mem_w   = last;
                state_d = last ? FETCH : MEMWRITE;
            end
            EXECR: begin
                AluSrcA = 2'b10;
                AluOp   = alu_dec(Funct3, Funct7b5);
                state_d = ALUWB;
            end
            EXECI: begin
                AluSrcA = 2'b10;
                AluSrcB = 2'b01;
                AluOp   = alu_dec(Funct3, 1'b0);
                state_d = ALUWB;
            end
            ALUWB: begin
                reg_w   = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                AluSrcA = 2'b10;
                AluOp   = 3'b001;
                branch  = ~bad_br;
                state_d = bad_br ? TRAP : FETCH;
            end
            JAL: begin
                AluSrcA   = 2'b01;
                AluSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = ALUWB;
            end
            LUI: begin
                AluSrcA = 2'b11;
                AluSrcB = 2'b01;
                state_d = ALUWB;
            end
            default: state_d = state;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench for multicycle_controller (MEM_WAIT=0 and MEM_WAIT=2 instances)
module tb_multicycle_controller;
    typedef struct {
        string       n;
        logic [17:0] v;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] Opcode;
    logic [2:0] Funct3;
    logic       Funct7b5;
    logic       Zero;
    logic       sel;
    wire  [17:0] o0;
    wire  [17:0] o2;
    exp_t       q[$];
    exp_t       e;
    logic [17:0] got;
    int         n_vec = 0;
    int         n_bad = 0;
    always #5 clk = ~clk;
    multicycle_controller #(.MEM_WAIT(0)) dut0 (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Funct3(Funct3), .Funct7b5(Funct7b5), .Zero(Zero),
        .PcEn(o0[16]), .AdrSrc(o0[15]), .MemWrite(o0[14]), .IrWrite(o0[13]), .RegWrite(o0[12]),
        .Immsrc(o0[11:9]), .AluSrcA(o0[8:7]), .AluSrcB(o0[6:5]), .AluOp(o0[4:2]), .ResultSrc(o0[1:0])
`ifdef CTRL_ILLEGAL_TRAP_EN
        , .Illegal(o0[17])
`endif
    );
    multicycle_controller #(.MEM_WAIT(2)) dut2 (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Funct3(Funct3), .Funct7b5(Funct7b5), .Zero(Zero),
        .PcEn(o2[16]), .AdrSrc(o2[15]), .MemWrite(o2[14]), .IrWrite(o2[13]), .RegWrite(o2[12]),
        .Immsrc(o2[11:9]), .AluSrcA(o2[8:7]), .AluSrcB(o2[6:5]), .AluOp(o2[4:2]), .ResultSrc(o2[1:0])
`ifdef CTRL_ILLEGAL_TRAP_EN
        , .Illegal(o2[17])
`endif
    );
`ifndef CTRL_ILLEGAL_TRAP_EN
    assign o0[17] = 1'b0;
    assign o2[17] = 1'b0;
`endif
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e   = q.pop_front();
            got = sel ? o2 : o0;
            n_vec++;
            if (got !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.n, got, e.v);
            end
        end
    end
    function automatic logic [17:0] v(input logic pc, adr, mw, ir, rw, input logic [2:0] imm,
                                      input logic [1:0] a, b, input logic [2:0] op, input logic [1:0] rs);
        return {1'b0, pc, adr, mw, ir, rw, imm, a, b, op, rs};
    endfunction
    task automatic step(input string n, input logic [17:0] val);
        q.push_back('{n, val});
        @(posedge clk);
        #1;
    endtask
    task automatic set_inst(input logic [31:0] inst);
        Opcode   = inst[6:0];
        Funct3   = inst[14:12];
        Funct7b5 = inst[30];
    endtask
    task automatic set_f(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        Opcode   = op;
        Funct3   = f3;
        Funct7b5 = f7;
    endtask
    task automatic t_reset(input string n, input logic [2:0] imm);
        step(n, v(0, 0, 0, 0, 0, imm, 2'b00, 2'b10, 3'b000, 2'b10));
    endtask
    task automatic t_fetch(input logic [2:0] imm);
        step("fetch", v(1, 0, 0, 1, 0, imm, 2'b00, 2'b10, 3'b000, 2'b10));
    endtask
    task automatic t_fetch_wait(input logic [2:0] imm);
        step("fetch_wait", v(0, 0, 0, 0, 0, imm, 2'b00, 2'b10, 3'b000, 2'b10));
    endtask
    task automatic t_decode(input logic [2:0] imm);
        step("decode", v(0, 0, 0, 0, 0, imm, 2'b01, 2'b01, 3'b000, 2'b00));
    endtask
    task automatic t_aluwb(input logic [2:0] imm);
        step("aluwb", v(0, 0, 0, 0, 1, imm, 2'b00, 2'b00, 3'b000, 2'b00));
    endtask
    task automatic do_r(input logic f7, input logic [2:0] f3, input logic [2:0] op, input string n);
        set_f(7'b0110011, f3, f7);
        t_fetch(3'b000);
        t_decode(3'b000);
        step(n, v(0, 0, 0, 0, 0, 3'b000, 2'b10, 2'b00, op, 2'b00));
        t_aluwb(3'b000);
    endtask
    task automatic do_i(input logic f7, input logic [2:0] f3, input logic [2:0] op, input string n);
        set_f(7'b0010011, f3, f7);
        t_fetch(3'b000);
        t_decode(3'b000);
        step(n, v(0, 0, 0, 0, 0, 3'b000, 2'b10, 2'b01, op, 2'b00));
        t_aluwb(3'b000);
    endtask
    task automatic do_br(input logic [2:0] f3, input logic z, input logic pc, input string n);
        set_f(7'b1100011, f3, 1'b0);
        Zero = z;
        t_fetch(3'b010);
        t_decode(3'b010);
        step(n, v(pc, 0, 0, 0, 0, 3'b010, 2'b10, 2'b00, 3'b001, 2'b00));
        Zero = 1'b0;
    endtask
    initial begin
        sel  = 1'b0;
        rst  = 1'b1;
        Zero = 1'b0;
        set_inst(32'h002081B3);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        t_reset("reset", 3'b000);
        t_reset("reset_hold", 3'b000);
        rst = 1'b1;
        do_r(1'b0, 3'b000, 3'b000, "execr_add");
        do_r(1'b1, 3'b000, 3'b001, "execr_sub");
        do_r(1'b0, 3'b111, 3'b010, "execr_and");
        do_r(1'b0, 3'b110, 3'b011, "execr_or");
        do_r(1'b0, 3'b010, 3'b100, "execr_slt");
        do_r(1'b0, 3'b100, 3'b101, "execr_xor");
        do_i(1'b1, 3'b000, 3'b000, "execi_addi_f7set");
        do_i(1'b0, 3'b111, 3'b010, "execi_andi");
        do_i(1'b0, 3'b110, 3'b011, "execi_ori");
        do_i(1'b0, 3'b010, 3'b100, "execi_slti");
        do_i(1'b0, 3'b100, 3'b101, "execi_xori");
        set_inst(32'h0000A183);
        t_fetch(3'b000);
        t_decode(3'b000);
        step("lw_memadr", v(0, 0, 0, 0, 0, 3'b000, 2'b10, 2'b01, 3'b000, 2'b00));
        step("lw_memread", v(0, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 3'b000, 2'b00));
        step("lw_memwb", v(0, 0, 0, 0, 1, 3'b000, 2'b00, 2'b00, 3'b000, 2'b01));
        set_inst(32'h0030A023);
        t_fetch(3'b001);
        t_decode(3'b001);
        step("sw_memadr", v(0, 0, 0, 0, 0, 3'b001, 2'b10, 2'b01, 3'b000, 2'b00));
        step("sw_memwrite", v(0, 1, 1, 0, 0, 3'b001, 2'b00, 2'b00, 3'b000, 2'b00));
        do_br(3'b000, 1'b1, 1'b1, "beq_taken");
        do_br(3'b000, 1'b0, 1'b0, "beq_not_taken");
        do_br(3'b001, 1'b1, 1'b0, "bne_not_taken");
        do_br(3'b001, 1'b0, 1'b1, "bne_taken");
        set_inst(32'h008000EF);
        t_fetch(3'b011);
        t_decode(3'b011);
        step("jal", v(1, 0, 0, 0, 0, 3'b011, 2'b01, 2'b10, 3'b000, 2'b00));
        t_aluwb(3'b011);
        set_f(7'b0110111, 3'b000, 1'b0);
        t_fetch(3'b100);
        t_decode(3'b100);
        step("lui", v(0, 0, 0, 0, 0, 3'b100, 2'b11, 2'b01, 3'b000, 2'b00));
        t_aluwb(3'b100);
        set_inst(32'h002081B3);
        t_fetch(3'b000);
        t_decode(3'b000);
        rst = 1'b0;
        t_reset("rst_in_execr", 3'b000);
        rst = 1'b1;
        do_r(1'b0, 3'b000, 3'b000, "execr_after_abort");
`ifndef CTRL_ILLEGAL_TRAP_EN
        do_br(3'b010, 1'b1, 1'b0, "branch_bad_funct3");
        set_f(7'b1111111, 3'b000, 1'b0);
        t_fetch(3'b000);
        t_decode(3'b000);
        set_inst(32'h002081B3);
        t_fetch(3'b000);
        t_decode(3'b000);
        step("execr_after_illegal", v(0, 0, 0, 0, 0, 3'b000, 2'b10, 2'b00, 3'b000, 2'b00));
        t_aluwb(3'b000);
`else
        set_f(7'b1111111, 3'b000, 1'b0);
        Zero = 1'b1;
        t_fetch(3'b000);
        t_decode(3'b000);
        for (int i = 0; i < 3; i++) step("halt", 18'h20000);
        rst = 1'b0;
        t_reset("halt_reset", 3'b000);
        rst = 1'b1;
        Zero = 1'b0;
        do_r(1'b0, 3'b000, 3'b000, "execr_after_halt");
`endif
        sel = 1'b1;
        rst = 1'b0;
        t_reset("reset_wait2", 3'b000);
        rst = 1'b1;
        do_r(1'b0, 3'b000, 3'b000, "wait2_execr");
        set_inst(32'h0000A183);
        t_fetch_wait(3'b000);
        t_fetch_wait(3'b000);
        t_fetch(3'b000);
        t_decode(3'b000);
        step("w2_lw_memadr", v(0, 0, 0, 0, 0, 3'b000, 2'b10, 2'b01, 3'b000, 2'b00));
        for (int i = 0; i < 3; i++) step("w2_lw_memread", v(0, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 3'b000, 2'b00));
        step("w2_lw_memwb", v(0, 0, 0, 0, 1, 3'b000, 2'b00, 2'b00, 3'b000, 2'b01));
        set_inst(32'h0030A023);
        t_fetch_wait(3'b001);
        t_fetch_wait(3'b001);
        t_fetch(3'b001);
        t_decode(3'b001);
        step("w2_sw_memadr", v(0, 0, 0, 0, 0, 3'b001, 2'b10, 2'b01, 3'b000, 2'b00));
        for (int i = 0; i < 2; i++) step("w2_sw_memwait", v(0, 1, 0, 0, 0, 3'b001, 2'b00, 2'b00, 3'b000, 2'b00));
        step("w2_sw_memwrite", v(0, 1, 1, 0, 0, 3'b001, 2'b00, 2'b00, 3'b000, 2'b00));
        @(posedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle RV32I core. Sits directly upstream of the datapath and drives every datapath control input.
- Decodes opcode/funct fields from the instruction register and Zero from the ALU.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK per instruction.
- Supported: add, sub, and, or, slt, xor; addi, andi, ori, slti, xori; lw, sw, beq, bne, jal, lui.

Parameters:
- MEM_WAIT, 0 — extra wait cycles held in FETCH, MEMREAD and MEMWRITE before advancing (0..15).

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- Opcode  in  7  Inst[6:0]
- Funct3  in  3  Inst[14:12]
- Funct7b5  in  1  Inst[30]
- Zero  in  1  ALU zero flag
- PcEn  out  1  PC load enable
- AdrSrc  out  1  0=PC, 1=Result
- MemWrite  out  1  memory write enable
- IrWrite  out  1  instruction register load
- RegWrite  out  1  register file write
- Immsrc  out  3  000=I, 001=S, 010=B, 011=J, 100=U
- AluSrcA  out  2  00=PC, 01=OldPC, 10=RegA, 11=zero
- AluSrcB  out  2  00=RegB, 01=Imm, 10=4
- AluOp  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor
- ResultSrc  out  2  00=AluOutReg, 01=MDR, 10=AluOut

Behaviour:
- Reset: rst low forces state=FETCH and wait counter=0.
  - While rst is low, PcEn, IrWrite, RegWrite and MemWrite are forced 0 combinationally; mux selects take their FETCH values.
- Outputs are Moore, decoded from state, except:
  - PcEn = PCUpdate | (Branch & taken), where taken = Zero for beq (Funct3=000) and ~Zero for bne (Funct3=001).
  - Immsrc is decoded combinationally from Opcode in every state.
- Unlisted signals in a state are 0.
- FETCH: AdrSrc=0, A=00, B=10, add, ResultSrc=10.
  - IrWrite=1 and PCUpdate=1 only in the last wait cycle. Next state DECODE.
- DECODE: A=01, B=01, add (AluOutReg gets branch/jal target).
  - Next state by Opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 0110111 -> LUI.
  - Any other opcode -> illegal handling (see Optional Feature).
- MEMADR: A=10, B=01, add. Next MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: AdrSrc=1, ResultSrc=00; holds MEM_WAIT extra cycles; next MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1; next FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00; MemWrite=1 in last wait cycle only; next FETCH.
- EXECR: A=10, B=00. AluOp from {Funct7b5, Funct3}:
  - 0/000 add, 1/000 sub, 111 and, 110 or, 010 slt, 100 xor.
  - Next ALUWB.
- EXECI: A=10, B=01. Same Funct3 map; Funct7b5 ignored (always add for 000). Next ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
- BRANCH: A=10, B=00, sub, ResultSrc=00, Branch=1; next FETCH.
  - Funct3 other than 000/001 is treated as illegal.
- JAL: A=01, B=10, add, ResultSrc=00, PCUpdate=1; next ALUWB (rd gets old PC+4).
- LUI: A=11, B=01, add; next ALUWB.
- Wait counter:
  - Loads MEM_WAIT on entry to FETCH, MEMREAD and MEMWRITE.
  - Decrements each cycle; the state advances when it reaches 0.
  - MEM_WAIT=0 gives single-cycle states.
- Cycle counts at MEM_WAIT=0: R/I/lui/jal/sw 4; lw 5; branch 3.
- rst asserted mid-instruction aborts immediately; no write enable is asserted afterward until FETCH restarts.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN
- Defined:
  - Illegal opcode or branch Funct3 enters HALT.
  - HALT: all enables 0, state held until reset.
  - Adds output port Illegal (1 bit), which is 1 only in HALT.
- Undefined:
  - Illegal instruction is a NOP: DECODE/BRANCH return to FETCH with no write enables.
  - No Illegal port.

Test Plan:
- Reset, then release with Opcode=0110011 (add x3,x1,x2 = 0x002081B3) -> states FETCH, DECODE, EXECR, ALUWB.
  - AluOp=000 in EXECR; RegWrite=1 only in cycle 4; IrWrite/PcEn=1 only in cycle 1.
- lw 0x0000A183 then sw 0x0030A023 -> lw takes 5 cycles with RegWrite and ResultSrc=01 in cycle 5.
  - sw takes 4 cycles with MemWrite=1, AdrSrc=1 in cycle 4 only.
- beq (Funct3=000) with Zero=1 -> PcEn=1 in cycle 3; Zero=0 -> PcEn=0.
  - bne (Funct3=001) gives the inverse result.
- jal 0x008000EF -> cycle 3: PcEn=1, A=01, B=10; cycle 4: RegWrite=1, ResultSrc=00.
- MEM_WAIT=2 with lw -> FETCH lasts 3 cycles with IrWrite only in the third; MEMREAD lasts 3 cycles; total 9 cycles.
- Opcode=1111111:
  - With macro: HALT, Illegal=1, no enables until rst low.
  - Without macro: back to FETCH after 2 cycles, no writes.
  - rst pulsed low during EXECR -> RegWrite never asserts for that instruction.
